// File: rtl/calculator_pkg.sv
// Shared calculator definitions: SRAM geometry and the port-arbiter owner encoding.
package calculator_pkg;

  localparam int ADDR_W                = 8;
  localparam int MEM_WORD_SIZE         = 32;
  localparam int ARB_MAX_BURST_DEFAULT = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN0     = 2'd1,
    OWN1     = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter for the single-port calculator SRAM, with bounded
// burst lock and a one-cycle read-valid strobe per port.
module sram_port_arbiter
  import calculator_pkg::*;
#(
  parameter int MAX_BURST = ARB_MAX_BURST_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req0_i,
  input  logic                     lock0_i,
  input  logic                     we0_i,
  input  logic [ADDR_W-1:0]        addr0_i,
  input  logic [MEM_WORD_SIZE-1:0] wdata0_i,
  output logic                     gnt0_o,
  output logic                     rvalid0_o,
  input  logic                     req1_i,
  input  logic                     lock1_i,
  input  logic                     we1_i,
  input  logic [ADDR_W-1:0]        addr1_i,
  input  logic [MEM_WORD_SIZE-1:0] wdata1_i,
  output logic                     gnt1_o,
  output logic                     rvalid1_o,
  output logic [MEM_WORD_SIZE-1:0] rdata_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [MEM_WORD_SIZE-1:0] mem_wdata_o,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_owner_t       r_owner;
  logic             r_lock;
  logic             r_last_gnt;  // 1: port 1 was granted most recently
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_rvalid0;
  logic             r_rvalid1;

  logic w_gnt0;
  logic w_gnt1;
  logic w_cap;

  // Lock is captured with the grant so it applies to the following cycle;
  // the burst cap only bites while the other port is waiting.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_cap  = (r_burst_cnt == CNT_MAX);
    if (rst_i) begin
      w_gnt0 = 1'b0;
    end else if ((r_owner == OWN0) && r_lock && req0_i && !(req1_i && w_cap)) begin
      w_gnt0 = 1'b1;
    end else if ((r_owner == OWN1) && r_lock && req1_i && !(req0_i && w_cap)) begin
      w_gnt1 = 1'b1;
    end else if (req0_i && req1_i) begin
      if (r_last_gnt) w_gnt0 = 1'b1;
      else            w_gnt1 = 1'b1;
    end else if (req0_i) begin
      w_gnt0 = 1'b1;
    end else if (req1_i) begin
      w_gnt1 = 1'b1;
    end else begin
      w_gnt0 = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner     <= OWN_NONE;
      r_lock      <= 1'b0;
      r_last_gnt  <= 1'b1;
      r_burst_cnt <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
    end else begin
      r_lock    <= (w_gnt0 & lock0_i) | (w_gnt1 & lock1_i);
      r_rvalid0 <= w_gnt0 & ~we0_i;
      r_rvalid1 <= w_gnt1 & ~we1_i;
      if (w_gnt0 || w_gnt1) begin
        r_owner    <= w_gnt0 ? OWN0 : OWN1;
        r_last_gnt <= w_gnt1;
        if ((w_gnt0 && r_owner == OWN0) || (w_gnt1 && r_owner == OWN1)) begin
          r_burst_cnt <= w_cap ? CNT_MAX : r_burst_cnt + CNT_ONE;
        end else begin
          r_burst_cnt <= CNT_ONE;
        end
      end else begin
        r_owner     <= OWN_NONE;
        r_burst_cnt <= '0;
      end
    end
  end

  assign gnt0_o      = w_gnt0;
  assign gnt1_o      = w_gnt1;
  assign mem_read_o  = (w_gnt0 & ~we0_i) | (w_gnt1 & ~we1_i);
  assign mem_write_o = (w_gnt0 & we0_i) | (w_gnt1 & we1_i);
  assign mem_addr_o  = w_gnt0 ? addr0_i : (w_gnt1 ? addr1_i : '0);
  assign mem_wdata_o = w_gnt0 ? wdata0_i : (w_gnt1 ? wdata1_i : '0);

  // Outputs are forced low while reset is held so a read in flight is dropped.
  assign rvalid0_o = r_rvalid0 & ~rst_i;
  assign rvalid1_o = r_rvalid1 & ~rst_i;
  assign rdata_o   = (rvalid0_o | rvalid1_o) ? mem_rdata_i : '0;

endmodule
